reg_index_encoder: RTL and testbench

Sequential 32-to-5 encoder: the inverse of the register-file write-select decoder. It accepts a 32-bit register-set mask, for example pending write-backs or a scoreboard clear vector. It then emits the index of each set bit, one per handshake, in fixed priority order. It sits between mask-producing logic (hazard/scoreboard) and any consumer that drives a 5-bit `ctrl_writeReg`-style port.

---
 rtl/reg_index_encoder.sv | 79 +++++++
 tb/tb_reg_index_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_index_encoder.sv
// Sequential 32-to-5 encoder: drains a register-set mask one index per handshake.
// Optional macro REG_ENC_MSB_FIRST_EN reverses the priority so the highest set bit goes first.
module reg_index_encoder (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic [5:0]  pending
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [4:0]  idx;
  logic [5:0]  cnt;

  // Priority pick from registered state only, so the index holds during a stall.
  always_comb begin
    idx = '0;
`ifdef REG_ENC_MSB_FIRST_EN
    for (int i = 0; i < 32; i++)
      if (pend_q[i]) idx = 5'(i);
`else
    for (int i = 31; i >= 0; i--)
      if (pend_q[i]) idx = 5'(i);
`endif
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++)
      cnt = cnt + {5'b0, pend_q[i]};
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pend_d = in_vec;
          if (in_vec != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pend_d = pend_q & ~(32'd1 << idx);
          if (pend_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_index = idx;
  assign out_last  = (state_q == DRAIN) && (cnt == 6'd1);
  assign pending   = cnt;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_reg_index_encoder.sv
// Scoreboard bench for reg_index_encoder: stimulus pushes expected beats, a monitor pops on handshakes.
module tb_reg_index_encoder;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic        out_last;
  logic [5:0]  pending;

  typedef struct packed {
    logic [4:0] index;
    logic       last;
    logic [5:0] pend;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  reg_index_encoder dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_last   (out_last),
    .pending    (pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int index, input bit last, input int pend);
    beat_t b;
    b.index = 5'(index);
    b.last  = last;
    b.pend  = 6'(pend);
    exp_q.push_back(b);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a mask for one accepted cycle; returns one cycle after the accepting edge.
  task automatic send(input logic [31:0] mask);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("in_ready_before_send", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_vec   = mask;
    step();
    in_valid = 1'b0;
    in_vec   = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check(name, {31'b0, in_ready}, 32'd1);
  endtask

  // Monitor: every handshake must match the next expected beat.
  always @(negedge clock) begin
    if (!ctrl_reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got index %0d with no beat expected", out_index);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_index", {27'b0, out_index}, {27'b0, e.index});
        check("beat_last", {31'b0, out_last}, {31'b0, e.last});
        check("beat_pending", {26'b0, pending}, {26'b0, e.pend});
      end
    end
  end

  initial begin
    ctrl_reset = 1'b1;
    in_valid   = 1'b0;
    in_vec     = '0;
    out_ready  = 1'b0;
    step();
    step();
    ctrl_reset = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_index", {27'b0, out_index}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_pending", {26'b0, pending}, 32'd0);

    // Single-bit mask: one beat, bubble, then ready again.
    out_ready = 1'b1;
    push(0, 1'b1, 1);
    send(32'h0000_0001);
    check("m1_out_valid_k1", {31'b0, out_valid}, 32'd1);
    check("m1_in_ready_k1", {31'b0, in_ready}, 32'd0);
    step();
    check("m1_in_ready_k2", {31'b0, in_ready}, 32'd1);
    check("m1_out_valid_k2", {31'b0, out_valid}, 32'd0);

    // Three-bit mask drained back to back.
`ifdef REG_ENC_MSB_FIRST_EN
    push(31, 1'b0, 3);
    push(2, 1'b0, 2);
    push(0, 1'b1, 1);
`else
    push(0, 1'b0, 3);
    push(2, 1'b0, 2);
    push(31, 1'b1, 1);
`endif
    send(32'h8000_0005);
    step();
    step();
    check("m3_out_valid_last_cycle", {31'b0, out_valid}, 32'd1);
    step();
    check("m3_in_ready_after", {31'b0, in_ready}, 32'd1);
    check("m3_queue_drained", exp_q.size(), 32'd0);

    // All-zero mask is swallowed without output.
    send(32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      check("zero_out_valid", {31'b0, out_valid}, 32'd0);
      check("zero_in_ready", {31'b0, in_ready}, 32'd1);
      step();
    end

    // Stall with a held index; in_valid during DRAIN ignored.
    out_ready = 1'b0;
`ifdef REG_ENC_MSB_FIRST_EN
    push(5, 1'b0, 2);
    push(4, 1'b1, 1);
`else
    push(4, 1'b0, 2);
    push(5, 1'b1, 1);
`endif
    send(32'h0000_0030);
    in_valid = 1'b1;
    in_vec   = 32'h0000_00FF;
    for (int i = 0; i < 3; i++) begin
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
`ifdef REG_ENC_MSB_FIRST_EN
      check("stall_hold_index", {27'b0, out_index}, 32'd5);
`else
      check("stall_hold_index", {27'b0, out_index}, 32'd4);
`endif
      check("stall_pending", {26'b0, pending}, 32'd2);
      step();
    end
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    step();
    step();
    check("stall_in_ready_after", {31'b0, in_ready}, 32'd1);
    check("stall_pending_after", {26'b0, pending}, 32'd0);
    check("stall_queue_drained", exp_q.size(), 32'd0);

    // All-ones mask interrupted by reset after two beats.
`ifdef REG_ENC_MSB_FIRST_EN
    push(31, 1'b0, 32);
    push(30, 1'b0, 31);
`else
    push(0, 1'b0, 32);
    push(1, 1'b0, 31);
`endif
    send(32'hFFFF_FFFF);
    step();
    step();
    out_ready = 1'b0;
    check("ones_pending_30", {26'b0, pending}, 32'd30);
`ifdef REG_ENC_MSB_FIRST_EN
    check("ones_index_3rd", {27'b0, out_index}, 32'd29);
`else
    check("ones_index_3rd", {27'b0, out_index}, 32'd2);
`endif
    ctrl_reset = 1'b1;
    step();
    ctrl_reset = 1'b0;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_pending", {26'b0, pending}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_queue_drained", exp_q.size(), 32'd0);

    // Reset and in_valid together: the mask must not be captured.
    ctrl_reset = 1'b1;
    in_valid   = 1'b1;
    in_vec     = 32'h0000_0004;
    step();
    ctrl_reset = 1'b0;
    in_valid   = 1'b0;
    in_vec     = '0;
    check("rstvld_out_valid", {31'b0, out_valid}, 32'd0);
    check("rstvld_pending", {26'b0, pending}, 32'd0);

    // Fresh mask after reset.
    out_ready = 1'b1;
    push(8, 1'b1, 1);
    send(32'h0000_0100);
    wait_idle("m8_idle_timeout");
    step();
    check("m8_out_valid_after", {31'b0, out_valid}, 32'd0);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
